// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run controller: state encoding, mode
// constants and the registered output bundle.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RST_SEQ = 3'd1,
    ST_RUN     = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [1:0] MODE_RUN_N = 2'b00;
  localparam logic [1:0] MODE_FREE  = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;

  // Registered controls driven to the datapath and status outputs.
  typedef struct packed {
    logic core_en;
    logic core_reset;
    logic busy;
    logic done;
  } outs_t;

  localparam outs_t OUTS_RESET = '{core_en: 1'b0, core_reset: 1'b1,
                                   busy: 1'b0, done: 1'b0};

  // The unused encoding 11 behaves as run-N.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_RUN_N : m;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of
// wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] q
);

  // Count enabled cycles; clear has priority over enable.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (reset || clear) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/run_controller.sv
// Sequences a datapath through reset, a counted, free or single-step run,
// and a done state, with all outputs registered.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int RST_CYCLES     = 4,
  parameter int DEFAULT_CYCLES = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  input  logic             step,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] run_cycles,
  output logic             core_en,
  output logic             core_reset,
  output logic [CNT_W-1:0] cycle_count,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] DEF_TARGET = CNT_W'(DEFAULT_CYCLES);
  localparam logic [7:0]       RST_LOAD   = 8'(RST_CYCLES - 1);

  state_t           state_q, state_d;
  logic             step_q, step_d;       // current PAUSE cycle is a stepped one
  logic [7:0]       rst_cnt_q, rst_cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] last_cnt;
  outs_t            outs_q, outs_d;
  logic             start_ok;

  // Count value seen during the final enabled cycle of a run-N.
  assign last_cnt = target_q - CNT_W'(1);

  // The counter advances on exactly the cycles where core_en is high.
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (start_ok),
    .en    (outs_q.core_en),
    .q     (cycle_count)
  );

  // State register plus latched run configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      step_q    <= 1'b0;
      rst_cnt_q <= '0;
      mode_q    <= MODE_RUN_N;
      target_q  <= DEF_TARGET;
      outs_q    <= OUTS_RESET;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      rst_cnt_q <= rst_cnt_d;
      mode_q    <= mode_d;
      target_q  <= target_d;
      outs_q    <= outs_d;
    end
  end

  // Next-state and configuration-latch decisions.
  always_comb begin
    // NOTE: defaulting every output first keeps this block free of latches.
    state_d   = state_q;
    step_d    = 1'b0;
    rst_cnt_d = rst_cnt_q;
    mode_d    = mode_q;
    target_d  = target_q;
    start_ok  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_ok  = 1'b1;
          state_d   = ST_RST_SEQ;
          rst_cnt_d = RST_LOAD;
          mode_d    = norm_mode(mode);
          target_d  = (run_cycles == '0) ? DEF_TARGET : run_cycles;
        end
      end
      ST_RST_SEQ: begin
        if (rst_cnt_q == 8'd0) begin
          state_d = (mode_q == MODE_STEP) ? ST_PAUSE : ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q - 8'd1;
        end
      end
      ST_RUN: begin
        if (halt) begin
          state_d = ST_DONE;
        end else if ((mode_q == MODE_RUN_N) && (cycle_count == last_cnt)) begin
          state_d = ST_DONE;
        end
      end
      ST_PAUSE: begin
        // A step arriving during the stepped cycle itself is dropped.
        if (halt) begin
          state_d = ST_DONE;
        end else if (step && !step_q) begin
          step_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    outs_d.core_en    = (state_d == ST_RUN) || step_d;
    outs_d.core_reset = (state_d == ST_IDLE) || (state_d == ST_RST_SEQ);
    outs_d.busy       = (state_d == ST_RST_SEQ) || (state_d == ST_RUN) ||
                        (state_d == ST_PAUSE);
    outs_d.done       = (state_d == ST_DONE);
  end

  assign core_en    = outs_q.core_en;
  assign core_reset = outs_q.core_reset;
  assign busy       = outs_q.busy;
  assign done       = outs_q.done;

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 Parameter: CNT_W, 16, width of cycle counter and run length.
REQ-002 Parameter: RST_CYCLES, 4, cycles core_reset is held during the start sequence (legal range 1..255).
REQ-003 Parameter: DEFAULT_CYCLES, 128, run length used when run_cycles is 0.
REQ-004 Port: clk  in  1  single clock; all logic on the rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: start  in  1  one-cycle request to begin a run.
REQ-007 Port: halt  in  1  one-cycle request to end a run early.
REQ-008 Port: step  in  1  one-cycle request for one enabled core cycle (step mode).
REQ-009 Port: mode  in  2  00 run-N, 01 free-run, 10 single-step; 11 is treated as 00.
REQ-010 Port: run_cycles  in  CNT_W  requested run length for run-N.
REQ-011 Port: core_en  out  1  registered clock enable to the datapath.
REQ-012 Port: core_reset  out  1  registered reset to the datapath.
REQ-013 Port: cycle_count  out  CNT_W  enabled cycles since the last start.
REQ-014 Port: busy  out  1  high in RST_SEQ, RUN and PAUSE.
REQ-015 Port: done  out  1  high in DONE.

Function
REQ-016 States: IDLE, RST_SEQ, RUN, PAUSE, DONE; all outputs registered.
REQ-017 IDLE: core_reset=1, core_en=0, busy=0, done=0.
REQ-018 start in IDLE or DONE: latch mode and target (run_cycles, or DEFAULT_CYCLES if 0), clear cycle_count, go to RST_SEQ next cycle.
REQ-019 RST_SEQ: core_reset=1, core_en=0 for exactly RST_CYCLES cycles; then RUN (modes 00/01) or PAUSE (mode 10).
REQ-020 RUN: core_en=1, core_reset=0; cycle_count increments on every cycle core_en=1.
REQ-021 Run-N: exactly target cycles with core_en=1; the cycle after the last enabled cycle is DONE with core_en=0 and cycle_count=target.
REQ-022 Free-run: RUN continues until halt; cycle_count saturates at all-ones with no wrap.
REQ-023 halt in RUN: core_en=0 from the next cycle; state DONE; cycle_count keeps its value.
REQ-024 PAUSE: core_en=0; step produces exactly one core_en=1 cycle on the next cycle, then PAUSE resumes; step during that enabled cycle is ignored.
REQ-025 halt and step together in PAUSE: halt wins; no enabled cycle; go to DONE.
REQ-026 DONE: core_en=0, core_reset=0 (datapath state preserved), done=1, cycle_count held.
REQ-027 start while busy is ignored; halt and step outside RUN/PAUSE are ignored; halt in RST_SEQ is ignored.
REQ-028 start and halt together in IDLE/DONE: start is honoured.

Reset
REQ-029 reset asserted: next edge gives state IDLE, core_reset=1, core_en=0, cycle_count=0, busy=0, done=0, latched mode=00, latched target=DEFAULT_CYCLES.
REQ-030 reset mid-run (any state) aborts immediately with the REQ-029 values; no further core_en cycle.

Structure
REQ-031 Package run_ctrl_pkg holds the state encoding and the mode constants (MODE_RUN_N, MODE_FREE, MODE_STEP).
REQ-032 One sub-module, sat_counter (parametrised width; clear, enable, saturating increment), implements cycle_count.

Verification
REQ-033 reset, then start with mode=00, run_cycles=10 -> core_reset high for 4 cycles, then exactly 10 core_en cycles, then done=1, cycle_count=10.
REQ-034 start with mode=00, run_cycles=0 -> 128 core_en cycles, cycle_count=128, done=1.
REQ-035 mode=01, halt after 37 enabled cycles -> core_en low the next cycle, cycle_count=37, done=1; with CNT_W=4, a free run of 20 cycles -> cycle_count=15.
REQ-036 mode=10, three step pulses then step+halt together -> exactly 3 single core_en pulses, cycle_count=3, done=1.
REQ-037 start repeated during RUN, and reset asserted at enabled cycle 5 of a 10-cycle run -> start has no effect; after reset: IDLE, cycle_count=0, core_reset=1, core_en=0.
REQ-038 start from DONE with mode=00, run_cycles=2 -> new reset sequence, cycle_count cleared to 0, then 2 core_en cycles, done=1.
